// File: rtl/ps2_frame_receiver.sv
// PS/2 receive front end: synchronizes and filters the PS/2 lines, then steps
// an external shift register one bit per falling clock edge and judges each frame.
module ps2_frame_receiver #(
    parameter int unsigned FRAME_BITS     = 11,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic shift_enable,
    output logic shift_in,
    output logic sr_clear,
    output logic busy,
    output logic frame_done,
    output logic frame_error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW = $clog2(FRAME_BITS + 1);

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_t;

    logic          clk_meta_q, clk_meta_d;
    logic          clk_sync_q, clk_sync_d;
    logic          data_meta_q, data_meta_d;
    logic          data_sync_q, data_sync_d;
    logic          filt_clk_q, filt_clk_d;
    logic          filt_prev_q, filt_prev_d;
    logic [3:0]    filt_cnt_q, filt_cnt_d;
    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          check_q, check_d;
    logic          stop_q, stop_d;
    logic          shift_enable_q, shift_enable_d;
    logic          shift_in_q, shift_in_d;
    logic          sr_clear_q, sr_clear_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_error_q, frame_error_d;
    logic          fe;

    assign fe = filt_prev_q & ~filt_clk_q;

    always_comb begin
        clk_meta_d  = ps2_clk;
        clk_sync_d  = clk_meta_q;
        data_meta_d = ps2_data;
        data_sync_d = data_meta_q;
        filt_prev_d = filt_clk_q;
        filt_clk_d  = filt_clk_q;
        filt_cnt_d  = '0;

        // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
        if (clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == 4'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        parity_d       = parity_q;
        timer_d        = timer_q;
        check_d        = 1'b0;
        stop_d         = stop_q;
        shift_enable_d = 1'b0;
        shift_in_d     = 1'b0;
        sr_clear_d     = 1'b0;
        frame_done_d   = 1'b0;
        frame_error_d  = 1'b0;

        // Verdict lands one cycle after the stop bit's shift pulse.
        if (check_q) begin
            frame_done_d  = parity_q & stop_q;
            frame_error_d = ~(parity_q & stop_q);
        end

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (fe && !data_sync_q) begin
                    sr_clear_d     = 1'b1;
                    shift_enable_d = 1'b1;
                    shift_in_d     = 1'b0;
                    state_d        = RECEIVE;
                    bit_cnt_d      = CW'(1);
                    parity_d       = 1'b0;
                end
            end
            RECEIVE: begin
                if (fe) begin
                    shift_enable_d = 1'b1;
                    shift_in_d     = data_sync_q;
                    timer_d        = '0;
                    if (bit_cnt_q == CW'(FRAME_BITS - 1)) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        check_d   = 1'b1;
                        stop_d    = data_sync_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        parity_d  = parity_q ^ data_sync_q;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    frame_error_d = 1'b1;
                    state_d       = IDLE;
                    bit_cnt_d     = '0;
                    timer_d       = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q     <= 1'b1;
            clk_sync_q     <= 1'b1;
            data_meta_q    <= 1'b1;
            data_sync_q    <= 1'b1;
            filt_clk_q     <= 1'b1;
            filt_prev_q    <= 1'b1;
            filt_cnt_q     <= '0;
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            parity_q       <= 1'b0;
            timer_q        <= '0;
            check_q        <= 1'b0;
            stop_q         <= 1'b0;
            shift_enable_q <= 1'b0;
            shift_in_q     <= 1'b0;
            sr_clear_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            clk_meta_q     <= clk_meta_d;
            clk_sync_q     <= clk_sync_d;
            data_meta_q    <= data_meta_d;
            data_sync_q    <= data_sync_d;
            filt_clk_q     <= filt_clk_d;
            filt_prev_q    <= filt_prev_d;
            filt_cnt_q     <= filt_cnt_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            parity_q       <= parity_d;
            timer_q        <= timer_d;
            check_q        <= check_d;
            stop_q         <= stop_d;
            shift_enable_q <= shift_enable_d;
            shift_in_q     <= shift_in_d;
            sr_clear_q     <= sr_clear_d;
            frame_done_q   <= frame_done_d;
            frame_error_q  <= frame_error_d;
        end
    end

    // busy stays up through the cycle the stop bit is shifted, before the verdict.
    assign busy         = (state_q == RECEIVE) | check_q;
    assign shift_enable = shift_enable_q;
    assign shift_in     = shift_in_q;
    assign sr_clear     = sr_clear_q;
    assign frame_done   = frame_done_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: drives PS/2 frames and judges the outputs
// against a frame-level reference model and a model of the downstream shift register.
module tb_ps2_frame_receiver;

    localparam int FL = 4;
    localparam int TO = 5000;

    logic clk = 1'b0;
    logic reset, ps2_clk, ps2_data;
    logic shift_enable, shift_in, sr_clear, busy, frame_done, frame_error;

    always #5 clk = ~clk;

    ps2_frame_receiver #(
        .FRAME_BITS(11),
        .FILTER_LEN(FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .shift_enable(shift_enable),
        .shift_in(shift_in),
        .sr_clear(sr_clear),
        .busy(busy),
        .frame_done(frame_done),
        .frame_error(frame_error)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int se_cnt = 0, done_cnt = 0, err_cnt = 0, viol = 0;
    int last_se_cyc = 0, done_cyc = 0, err_cyc = 0, se_first_cyc = -1, fall0_cyc = 0;
    logic shift_bits[$];
    logic [10:0] done_vals[$];
    logic [10:0] sr = '0;
    logic busy_prev = 1'b0;

    // Downstream shift register (load has priority) plus protocol observers.
    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_vals.push_back(sr);
        end
        if (frame_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (frame_done && frame_error) viol++;
        if ((frame_done || frame_error) && (busy || !busy_prev)) viol++;
        if (sr_clear && !(busy && shift_enable && !shift_in)) viol++;
        if (shift_enable) begin
            se_cnt++;
            last_se_cyc = cyc;
            shift_bits.push_back(shift_in);
            if (se_first_cyc < 0) se_first_cyc = cyc;
        end
        if (sr_clear) sr = '0;
        else if (shift_enable) sr = {sr[9:0], shift_in};
        busy_prev = busy;
    end

    int s_se, s_done, s_err, s_viol;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_scn();
        s_se = se_cnt; s_done = done_cnt; s_err = err_cnt; s_viol = viol;
        shift_bits.delete();
        done_vals.delete();
        se_first_cyc = -1;
    endtask

    // fb[i] is the i-th bit on the wire.
    function automatic logic [10:0] make_frame(input logic [7:0] code, input bit flip, input bit stop);
        logic [10:0] fb;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = code[i];
        fb[9]  = (~^code) ^ flip;
        fb[10] = stop;
        return fb;
    endfunction

    function automatic logic [10:0] exp_sr(input logic [10:0] fb);
        logic [10:0] r;
        for (int i = 0; i < 11; i++) r[10-i] = fb[i];
        return r;
    endfunction

    task automatic send_bits(input logic [10:0] fb, input int nbits, input int period,
                             input int glitch_bit, input int glitch_len);
        int half;
        half = period / 2;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fb[i];
            if (i == glitch_bit) begin
                tick(half / 2);
                ps2_clk = 1'b0;
                tick(glitch_len);
                ps2_clk = 1'b1;
                tick(half - half / 2 - glitch_len);
            end else begin
                tick(half);
            end
            ps2_clk = 1'b0;
            if (i == 0) fall0_cyc = cyc;
            tick(half);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_frame(input string name, input logic [10:0] fb, input int nbits);
        int  m_shifts;
        bit  m_done, m_err, bad;
        m_shifts = (fb[0] == 1'b0) ? nbits : 0;
        m_done   = (fb[0] == 1'b0) && (nbits == 11) && ((^fb[9:1]) == 1'b1) && fb[10];
        m_err    = (fb[0] == 1'b0) && !m_done;

        tests++;
        if (se_cnt - s_se !== m_shifts) begin
            fails++; $display("FAIL %s shifts: got %0d want %0d", name, se_cnt - s_se, m_shifts);
        end
        tests++;
        if (done_cnt - s_done !== int'(m_done)) begin
            fails++; $display("FAIL %s frame_done count: got %0d want %0d", name, done_cnt - s_done, m_done);
        end
        tests++;
        if (err_cnt - s_err !== int'(m_err)) begin
            fails++; $display("FAIL %s frame_error count: got %0d want %0d", name, err_cnt - s_err, m_err);
        end
        tests++;
        if (viol - s_viol !== 0) begin
            fails++; $display("FAIL %s protocol violations: got %0d want 0", name, viol - s_viol);
        end
        tests++;
        bad = (shift_bits.size() != m_shifts);
        for (int i = 0; i < shift_bits.size() && i < 11; i++) if (shift_bits[i] !== fb[i]) bad = 1'b1;
        if (bad) begin
            fails++; $display("FAIL %s shift_in sequence: got %0d bits, want %0d bits %b", name, shift_bits.size(), m_shifts, fb);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL %s busy after frame: got %b want 0", name, busy);
        end
        if (m_done) begin
            tests++;
            if (done_vals.size() != 1 || done_vals[0] !== exp_sr(fb)) begin
                fails++; $display("FAIL %s data_out: got %b want %b", name, (done_vals.size() > 0) ? done_vals[0] : 11'bx, exp_sr(fb));
            end
            tests++;
            if (done_cyc - last_se_cyc !== 1) begin
                fails++; $display("FAIL %s done latency: got %0d want 1", name, done_cyc - last_se_cyc);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        tick(3);
        tests++;
        if ({shift_enable, shift_in, sr_clear, busy, frame_done, frame_error} !== 6'b0) begin
            fails++; $display("FAIL reset outputs: got %b want 000000",
                              {shift_enable, shift_in, sr_clear, busy, frame_done, frame_error});
        end
        reset = 1'b0;
        tick(10);
    endtask

    task automatic test_good_frame();
        logic [10:0] fb;
        fb = make_frame(8'h1C, 1'b0, 1'b1);
        begin_scn();
        send_bits(fb, 11, 2000, -1, 0);
        tick(20);
        check_frame("good_1C", fb, 11);
        tests++;
        if (done_vals.size() != 1 || done_vals[0] !== 11'b0_00111000_0_1) begin
            fails++; $display("FAIL good_1C literal data_out: got %b want 00011100001",
                              (done_vals.size() > 0) ? done_vals[0] : 11'bx);
        end
        tests++;
        if (se_first_cyc - fall0_cyc !== 2 + FL + 1) begin
            fails++; $display("FAIL edge latency: got %0d want %0d", se_first_cyc - fall0_cyc, 2 + FL + 1);
        end
    endtask

    task automatic test_errors();
        logic [10:0] fb;
        fb = make_frame(8'h1C, 1'b1, 1'b1);
        begin_scn(); send_bits(fb, 11, 200, -1, 0); tick(20);
        check_frame("parity_err", fb, 11);
        fb = make_frame(8'h1C, 1'b0, 1'b0);
        begin_scn(); send_bits(fb, 11, 200, -1, 0); tick(20);
        check_frame("stop_err", fb, 11);
        fb = '1;
        begin_scn(); send_bits(fb, 1, 200, -1, 0); tick(20);
        check_frame("spurious_idle", fb, 1);
    endtask

    task automatic test_glitch();
        logic [10:0] fb;
        fb = make_frame(8'h1C, 1'b0, 1'b1);
        begin_scn(); send_bits(fb, 11, 200, 4, FL - 1); tick(20);
        check_frame("glitch", fb, 11);
    endtask

    task automatic test_timeout();
        logic [10:0] fb;
        fb = make_frame(8'h1C, 1'b0, 1'b1);
        begin_scn(); send_bits(fb, 5, 200, -1, 0); tick(TO + 100);
        check_frame("timeout", fb, 5);
        tests++;
        if (err_cyc - last_se_cyc !== TO) begin
            fails++; $display("FAIL timeout latency: got %0d want %0d", err_cyc - last_se_cyc, TO);
        end
        begin_scn(); send_bits(fb, 11, 200, -1, 0); tick(20);
        check_frame("after_timeout", fb, 11);
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] fb;
        fb = make_frame(8'h1C, 1'b0, 1'b1);
        begin_scn(); send_bits(fb, 6, 200, -1, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tests++;
        if ({shift_enable, shift_in, sr_clear, busy, frame_done, frame_error} !== 6'b0) begin
            fails++; $display("FAIL mid_reset outputs: got %b want 000000",
                              {shift_enable, shift_in, sr_clear, busy, frame_done, frame_error});
        end
        tick(TO + 100);
        tests++;
        if ((done_cnt - s_done) + (err_cnt - s_err) !== 0 || se_cnt - s_se !== 6) begin
            fails++; $display("FAIL mid_reset pulses: got done %0d err %0d shifts %0d want 0 0 6",
                              done_cnt - s_done, err_cnt - s_err, se_cnt - s_se);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] fa, fb;
        fa = make_frame(8'hF0, 1'b0, 1'b1);
        fb = make_frame(8'h1C, 1'b0, 1'b1);
        begin_scn();
        send_bits(fa, 11, 200, -1, 0);
        send_bits(fb, 11, 200, -1, 0);
        tick(20);
        tests++;
        if (done_cnt - s_done !== 2 || err_cnt - s_err !== 0 || viol - s_viol !== 0) begin
            fails++; $display("FAIL b2b pulses: got done %0d err %0d viol %0d want 2 0 0",
                              done_cnt - s_done, err_cnt - s_err, viol - s_viol);
        end
        tests++;
        if (done_vals.size() != 2 || done_vals[0] !== exp_sr(fa) || done_vals[1] !== exp_sr(fb)) begin
            fails++; $display("FAIL b2b data_out: got %0d frames, want %b then %b", done_vals.size(), exp_sr(fa), exp_sr(fb));
        end
    endtask

    task automatic test_random();
        logic [10:0] fb;
        int period, gl;
        for (int n = 0; n < 8; n++) begin
            fb = make_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
            period = 2 * $urandom_range(20, 100);
            gl = $urandom_range(1, FL - 1);
            begin_scn();
            send_bits(fb, 11, period, $urandom_range(1, 12), gl);
            tick(20);
            check_frame("random", fb, 11);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_errors();
        test_glitch();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
